// File: rtl/decoder_stream_host.sv
// Host side of the decoder controller byte protocol: serializes one syndrome frame
// into the controller input stream and assembles the controller response into one result word.
module decoder_stream_host #(
  parameter int          GRID_WIDTH_X = 4,
  parameter int          GRID_WIDTH_Z = 1,
  parameter int          GRID_WIDTH_U = 3,
  parameter int          ERASURE      = 1,
  parameter logic [7:0]  HEADER_BYTE  = 8'h01,
  localparam int PU     = GRID_WIDTH_X * GRID_WIDTH_Z,
  localparam int MB     = (PU + 7) / 8,
  localparam int EC     = GRID_WIDTH_U * GRID_WIDTH_U - (GRID_WIDTH_U - 1),
  localparam int EB     = (EC + 7) / 8,
  localparam int CC     = 2 * (GRID_WIDTH_X - 1) * GRID_WIDTH_Z + 1 + GRID_WIDTH_X * GRID_WIDTH_Z,
  localparam int CB     = (CC + 7) / 8,
  localparam int MEAS_W = PU * GRID_WIDTH_U,
  localparam int ERA_W  = EC * GRID_WIDTH_U,
  localparam int CORR_W = CC * GRID_WIDTH_U
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MEAS_W-1:0] frame_measurements_i,
  input  logic [ERA_W-1:0]  frame_erasures_i,
  input  logic              frame_valid_i,
  output logic              frame_ready_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic [CORR_W-1:0] result_corrections_o,
  output logic [7:0]        result_iterations_o,
  output logic [15:0]       result_cycles_o,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic              busy_o
);

  localparam int MAXB   = (MB > EB) ? ((MB > CB) ? MB : CB) : ((EB > CB) ? EB : CB);
  localparam int CW_RAW = $clog2(MAXB + 1);
  // The response header is three bytes long, so the byte counter needs at least two bits.
  localparam int CW     = (CW_RAW < 2) ? 2 : CW_RAW;
  localparam int RW     = (GRID_WIDTH_U < 2) ? 1 : $clog2(GRID_WIDTH_U + 1);

  localparam logic [CW-1:0]     MB_L      = CW'(MB);
  localparam logic [CW-1:0]     EB_L      = CW'(EB);
  localparam logic [CW-1:0]     CB_L      = CW'(CB);
  localparam logic [RW-1:0]     U_L       = RW'(GRID_WIDTH_U);
  localparam logic [MB*8-1:0]   MEAS_MASK = (MB*8)'({PU{1'b1}});
  localparam logic [EB*8-1:0]   ERA_MASK  = (EB*8)'({EC{1'b1}});
  localparam logic [CORR_W-1:0] CORR_ONES = CORR_W'({CC{1'b1}});

  // IDLE wait frame | SEND_* stream frame bytes | RECV_* collect response | DONE hold result
  typedef enum logic [2:0] {
    S_IDLE, S_SEND_HDR, S_SEND_MEAS, S_SEND_ERA, S_RECV_HDR, S_RECV_CORR, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       byte_q, byte_d;
  logic [RW-1:0]       round_q, round_d;
  logic [MEAS_W-1:0]   meas_q, meas_d;
  logic [ERA_W-1:0]    era_q, era_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic [7:0]          iter_q, iter_d;
  logic [15:0]         cyc_q, cyc_d;
  logic [CORR_W-1:0]   corr_q, corr_d;

  logic [CW-1:0]       byte_inc, limit;
  logic [RW-1:0]       round_inc;
  logic                byte_end;
  state_t              next_tx_state;
  logic [MB*8-1:0]     meas_pad;
  logic [EB*8-1:0]     era_pad;
  logic [7:0]          tx_byte;
  int                  corr_off;
  logic [CORR_W-1:0]   corr_rmask, corr_bmask, corr_wr;

  assign byte_inc  = byte_q + CW'(1);
  assign round_inc = round_q + RW'(1);
  assign limit     = (state_q == S_SEND_MEAS) ? MB_L :
                     (state_q == S_SEND_ERA)  ? EB_L :
                     (state_q == S_RECV_CORR) ? CB_L :
                     (state_q == S_RECV_HDR)  ? CW'(3) : CW'(1);
  assign byte_end  = (byte_inc == limit);

  assign next_tx_state = (state_q == S_SEND_HDR) ? S_SEND_MEAS :
                         (state_q == S_SEND_MEAS && ERASURE != 0) ? S_SEND_ERA : S_RECV_HDR;

  // Current round shifted down to bit 0, zero padded up to a whole number of bytes.
  assign meas_pad = (MB*8)'(meas_q >> (int'(round_q) * PU)) & MEAS_MASK;
  assign era_pad  = (EB*8)'(era_q >> (int'(round_q) * EC)) & ERA_MASK;
  assign tx_byte  = (state_q == S_SEND_MEAS) ? 8'(meas_pad >> (int'(byte_q) * 8)) :
                    (state_q == S_SEND_ERA)  ? 8'(era_pad >> (int'(byte_q) * 8)) : HEADER_BYTE;

  // Round mask drops the bits of a final byte that would spill into the next round.
  assign corr_off   = int'(round_q) * CC + int'(byte_q) * 8;
  assign corr_rmask = CORR_ONES << (int'(round_q) * CC);
  assign corr_bmask = CORR_W'(8'hFF) << corr_off;
  assign corr_wr    = (corr_q & ~(corr_bmask & corr_rmask)) |
                      ((CORR_W'(rx_data_i) << corr_off) & corr_rmask);

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    round_d    = round_q;
    meas_d     = meas_q;
    era_d      = era_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    iter_d     = iter_q;
    cyc_d      = cyc_q;
    corr_d     = corr_q;
    case (state_q)
      S_IDLE: begin
        if (frame_valid_i) begin
          meas_d  = frame_measurements_i;
          era_d   = frame_erasures_i;
          state_d = S_SEND_HDR;
        end
      end
      S_SEND_HDR, S_SEND_MEAS, S_SEND_ERA: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = tx_byte;
        end else if (tx_ready_i) begin
          tx_valid_d = 1'b0;
          if (byte_end) begin
            byte_d = '0;
            if (state_q == S_SEND_HDR || round_inc == U_L) begin
              round_d = '0;
              state_d = next_tx_state;
            end else begin
              round_d = round_inc;
            end
          end else begin
            byte_d = byte_inc;
          end
        end
      end
      S_RECV_HDR: begin
        if (rx_valid_i) begin
          case (byte_q)
            CW'(0):  iter_d      = rx_data_i;
            CW'(1):  cyc_d[15:8] = rx_data_i;
            default: cyc_d[7:0]  = rx_data_i;
          endcase
          if (byte_end) begin
            byte_d  = '0;
            state_d = S_RECV_CORR;
          end else begin
            byte_d = byte_inc;
          end
        end
      end
      S_RECV_CORR: begin
        if (rx_valid_i) begin
          corr_d = corr_wr;
          if (byte_end) begin
            byte_d = '0;
            if (round_inc == U_L) begin
              round_d = '0;
              state_d = S_DONE;
            end else begin
              round_d = round_inc;
            end
          end else begin
            byte_d = byte_inc;
          end
        end
      end
      S_DONE: begin
        if (result_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_q     <= '0;
      round_q    <= '0;
      meas_q     <= '0;
      era_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      iter_q     <= '0;
      cyc_q      <= '0;
      corr_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      round_q    <= round_d;
      meas_q     <= meas_d;
      era_q      <= era_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      iter_q     <= iter_d;
      cyc_q      <= cyc_d;
      corr_q     <= corr_d;
    end
  end

  assign frame_ready_o        = (state_q == S_IDLE);
  assign busy_o               = (state_q != S_IDLE);
  assign rx_ready_o           = (state_q == S_RECV_HDR) || (state_q == S_RECV_CORR);
  assign result_valid_o       = (state_q == S_DONE);
  assign tx_data_o            = tx_data_q;
  assign tx_valid_o           = tx_valid_q;
  assign result_iterations_o  = iter_q;
  assign result_cycles_o      = cyc_q;
  assign result_corrections_o = corr_q;

endmodule

// File: tb/tb_decoder_stream_host.sv
// Directed and randomized checks of decoder_stream_host against a byte-list reference model.
module tb_decoder_stream_host;

  localparam int X = 4, Z = 1, U = 3;
  localparam int PU = X * Z;
  localparam int MB = (PU + 7) / 8;
  localparam int EC = U * U - (U - 1);
  localparam int EB = (EC + 7) / 8;
  localparam int CC = (X - 1) * Z + (X - 1) * Z + 1 + X * Z;
  localparam int CB = (CC + 7) / 8;
  localparam int MEAS_W = PU * U, ERA_W = EC * U, CORR_W = CC * U;
  localparam int NRX = 3 + CB * U;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [MEAS_W-1:0] fm;  logic [ERA_W-1:0] fe;  logic fv, frame_ready;
  logic [7:0] tx_data;  logic tx_valid, tx_ready;
  logic [7:0] rx_data;  logic rx_valid, rx_ready;
  logic [CORR_W-1:0] res_corr;  logic [7:0] res_iter;  logic [15:0] res_cyc;
  logic res_valid, res_ready, busy;

  logic [MEAS_W-1:0] fm0;  logic [ERA_W-1:0] fe0;  logic fv0, frame_ready0;
  logic [7:0] tx_data0;  logic tx_valid0, rx_ready0;
  logic [CORR_W-1:0] res_corr0;  logic [7:0] res_iter0;  logic [15:0] res_cyc0;
  logic res_valid0, busy0;

  decoder_stream_host #(.GRID_WIDTH_X(X), .GRID_WIDTH_Z(Z), .GRID_WIDTH_U(U),
                        .ERASURE(1), .HEADER_BYTE(8'h01)) dut (
    .clk(clk), .reset(reset),
    .frame_measurements_i(fm), .frame_erasures_i(fe), .frame_valid_i(fv), .frame_ready_o(frame_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .result_corrections_o(res_corr), .result_iterations_o(res_iter), .result_cycles_o(res_cyc),
    .result_valid_o(res_valid), .result_ready_i(res_ready), .busy_o(busy));

  decoder_stream_host #(.GRID_WIDTH_X(X), .GRID_WIDTH_Z(Z), .GRID_WIDTH_U(U),
                        .ERASURE(0), .HEADER_BYTE(8'h01)) dut0 (
    .clk(clk), .reset(reset),
    .frame_measurements_i(fm0), .frame_erasures_i(fe0), .frame_valid_i(fv0), .frame_ready_o(frame_ready0),
    .tx_data_o(tx_data0), .tx_valid_o(tx_valid0), .tx_ready_i(1'b1),
    .rx_data_i(8'h00), .rx_valid_i(1'b0), .rx_ready_o(rx_ready0),
    .result_corrections_o(res_corr0), .result_iterations_o(res_iter0), .result_cycles_o(res_cyc0),
    .result_valid_o(res_valid0), .result_ready_i(1'b0), .busy_o(busy0));

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  int n_checks = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected byte stream: header, then each round's bits LSB first, padded to whole bytes.
  function automatic void build_tx(input logic [MEAS_W-1:0] m, input logic [ERA_W-1:0] e, input bit era);
    logic [7:0] b;
    exp_tx.delete();
    exp_tx.push_back(8'h01);
    for (int r = 0; r < U; r++)
      for (int k = 0; k < MB; k++) begin
        b = 8'h00;
        for (int i = 0; i < 8; i++) if (k * 8 + i < PU) b[i] = m[r * PU + k * 8 + i];
        exp_tx.push_back(b);
      end
    if (era)
      for (int r = 0; r < U; r++)
        for (int k = 0; k < EB; k++) begin
          b = 8'h00;
          for (int i = 0; i < 8; i++) if (k * 8 + i < EC) b[i] = e[r * EC + k * 8 + i];
          exp_tx.push_back(b);
        end
  endfunction

  function automatic void gen_rx();
    exp_rx.delete();
    for (int j = 0; j < NRX; j++) exp_rx.push_back(8'($urandom));
  endfunction

  function automatic void model_result(output logic [7:0] it, output logic [15:0] cy,
                                       output logic [CORR_W-1:0] co);
    logic [7:0] b;
    it = exp_rx[0];
    cy = {exp_rx[1], exp_rx[2]};
    co = '0;
    for (int j = 0; j < CB * U; j++) begin
      b = exp_rx[3 + j];
      for (int i = 0; i < 8; i++)
        if ((j % CB) * 8 + i < CC) co[(j / CB) * CC + (j % CB) * 8 + i] = b[i];
    end
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_frame_ready"}, 64'(frame_ready), 64'(1));
    chk({tag, "_tx_valid"}, 64'(tx_valid), 64'(0));
    chk({tag, "_tx_data"}, 64'(tx_data), 64'(0));
    chk({tag, "_rx_ready"}, 64'(rx_ready), 64'(0));
    chk({tag, "_result_valid"}, 64'(res_valid), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_results"}, {res_iter, res_cyc, 7'd0, res_corr}, 64'(0));
  endtask

  task automatic offer_frame(input logic [MEAS_W-1:0] m, input logic [ERA_W-1:0] e);
    int i;
    @(negedge clk);
    fm = m; fe = e; fv = 1'b1;
    for (i = 0; i < 50 && !frame_ready; i++) @(negedge clk);
    chk("accept_ready", 64'(frame_ready), 64'(1));
    @(negedge clk);
    fv = 1'b0; fm = ~m; fe = ~e;
    chk("accept_busy", 64'(busy), 64'(1));
    chk("accept_frame_ready", 64'(frame_ready), 64'(0));
  endtask

  // Collects the tx stream with random (or held) backpressure while junk is offered on rx.
  task automatic do_tx(input int hold_at);
    int n = 0, hold = 0, it;
    bit prev_xfer = 0, prev_stall = 0, prev_gap = 0, held = 0;
    logic [7:0] prev_data = 8'h00;
    for (it = 0; it < 400; it++) begin
      if (prev_xfer) chk("tx_gap", 64'(tx_valid), 64'(0));
      else if (prev_stall) begin
        chk("tx_stall_valid", 64'(tx_valid), 64'(1));
        chk("tx_stall_data", 64'(tx_data), 64'(prev_data));
      end else if (prev_gap && !rx_ready) chk("tx_next_valid", 64'(tx_valid), 64'(1));
      if (rx_ready) break;
      if (hold > 0) begin tx_ready = 1'b0; hold--; end
      else if (n == hold_at && tx_valid && !held) begin tx_ready = 1'b0; hold = 4; held = 1; end
      else tx_ready = ($urandom_range(3) != 0);
      rx_valid = 1'b1; rx_data = 8'($urandom);
      prev_gap = prev_xfer;
      prev_xfer = tx_valid && tx_ready;
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
      if (prev_xfer) begin
        if (n < exp_tx.size()) chk("tx_byte", 64'(tx_data), 64'(exp_tx[n]));
        else chk("tx_extra_byte", 64'(n), 64'(exp_tx.size()));
        n++;
      end
      @(negedge clk);
    end
    rx_valid = 1'b0; tx_ready = 1'b0;
    chk("tx_rx_ready_reached", 64'(rx_ready), 64'(1));
    chk("tx_count", 64'(n), 64'(exp_tx.size()));
  endtask

  task automatic do_rx(input int nbytes);
    int idx = 0, it;
    for (it = 0; it < 400 && idx < nbytes; it++) begin
      rx_valid = ($urandom_range(2) != 0);
      rx_data = exp_rx[idx];
      if (rx_valid && rx_ready) idx++;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("rx_count", 64'(idx), 64'(nbytes));
  endtask

  task automatic finish_result(input bit offer_next, input logic [MEAS_W-1:0] nm, input logic [ERA_W-1:0] ne);
    logic [7:0] it; logic [15:0] cy; logic [CORR_W-1:0] co;
    for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
    chk("res_valid", 64'(res_valid), 64'(1));
    model_result(it, cy, co);
    chk("res_iterations", 64'(res_iter), 64'(it));
    chk("res_cycles", 64'(res_cyc), 64'(cy));
    chk("res_corrections", 64'(res_corr), 64'(co));
    chk("res_rx_ready", 64'(rx_ready), 64'(0));
    if (offer_next) begin
      fm = nm; fe = ne; fv = 1'b1;
      repeat (10) begin
        @(negedge clk);
        chk("hold_frame_ready", 64'(frame_ready), 64'(0));
        chk("hold_result_valid", 64'(res_valid), 64'(1));
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("release_result_valid", 64'(res_valid), 64'(0));
    chk("release_busy", 64'(busy), 64'(0));
    chk("release_frame_ready", 64'(frame_ready), 64'(1));
    if (offer_next) begin
      @(negedge clk);
      fv = 1'b0; fm = ~nm; fe = ~ne;
      chk("b2b_busy", 64'(busy), 64'(1));
      chk("b2b_frame_ready", 64'(frame_ready), 64'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MEAS_W-1:0] m, m2;
    logic [ERA_W-1:0] e, e2;
    int n0;
    reset = 1'b1; fv = 0; fm = '0; fe = '0; tx_ready = 0; rx_valid = 0; rx_data = 0; res_ready = 0;
    fv0 = 0; fm0 = '0; fe0 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("reset");

    // Directed frame from the reference example.
    m = 12'hA5C; e = 21'h1F0F3;
    build_tx(m, e, 1);
    offer_frame(m, e);
    do_tx(-1);
    exp_rx.delete();
    exp_rx = '{8'h02, 8'h00, 8'h2F, 8'h55, 8'h03, 8'hAA, 8'h02, 8'hFF, 8'h01};
    do_rx(NRX);
    finish_result(1'b0, '0, '0);

    // Long tx stall inside the measurement bytes, then back-to-back frame offer.
    m = MEAS_W'($urandom); e = ERA_W'($urandom);
    build_tx(m, e, 1);
    offer_frame(m, e);
    do_tx(2);
    gen_rx();
    do_rx(NRX);
    m2 = MEAS_W'($urandom); e2 = ERA_W'($urandom);
    finish_result(1'b1, m2, e2);
    build_tx(m2, e2, 1);
    do_tx(-1);
    gen_rx();
    do_rx(NRX);
    finish_result(1'b0, '0, '0);

    // Reset after three correction bytes, then a clean frame.
    m = MEAS_W'($urandom); e = ERA_W'($urandom);
    build_tx(m, e, 1);
    offer_frame(m, e);
    do_tx(-1);
    gen_rx();
    do_rx(6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("midreset");

    for (int f = 0; f < 5; f++) begin
      m = MEAS_W'($urandom); e = ERA_W'($urandom);
      build_tx(m, e, 1);
      offer_frame(m, e);
      do_tx(f);
      gen_rx();
      do_rx(NRX);
      finish_result(1'b0, '0, '0);
    end

    // ERASURE=0 instance: header plus measurement bytes only.
    m = MEAS_W'($urandom); e = ERA_W'($urandom);
    build_tx(m, e, 0);
    @(negedge clk);
    fm0 = m; fe0 = e; fv0 = 1'b1;
    @(negedge clk);
    fv0 = 1'b0; fm0 = ~m; fe0 = ~e;
    n0 = 0;
    for (int i = 0; i < 100 && !rx_ready0; i++) begin
      if (tx_valid0) begin
        if (n0 < exp_tx.size()) chk("noera_tx_byte", 64'(tx_data0), 64'(exp_tx[n0]));
        n0++;
      end
      @(negedge clk);
    end
    chk("noera_rx_ready", 64'(rx_ready0), 64'(1));
    chk("noera_tx_count", 64'(n0), 64'(1 + MB * U));
    chk("noera_state_flags", {61'd0, busy0, frame_ready0, res_valid0}, 64'b100);
    chk("noera_results", {res_iter0, res_cyc0, 7'd0, res_corr0}, 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
